// File: rtl/button_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : button_array
// Purpose  : Multi-channel pushbutton conditioner. Each channel has a 2-flop
//            synchroniser and an independent debounce FSM with a symmetric
//            press/release filter and optional auto-repeat while held.
//
// Ports    : clk          in   system clock, rising edge
//            rst          in   asynchronous active-high reset
//            btn          in   [N_BTN] raw bouncing levels, 1 = pressed
//            repeat_en    in   [N_BTN] per-channel auto-repeat enable
//            level        out  [N_BTN] debounced level, registered
//            press        out  [N_BTN] one-cycle pulse on accepted press and on
//                              every auto-repeat, registered
//            btn_release  out  [N_BTN] one-cycle pulse on accepted release,
//                              registered ("release" is a reserved word in
//                              SystemVerilog, hence the prefixed name)
//
// Revision : 1.0  initial release
// ============================================================================
module button_array #(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_PERIOD = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn,
    input  logic [N_BTN-1:0] repeat_en,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] btn_release
);

    // One counter serves debounce and both repeat phases, so it is sized for
    // the largest of the three terminal counts.
    localparam int c_MAX_AB = (DEBOUNCE_PERIOD > REPEAT_DELAY) ? DEBOUNCE_PERIOD : REPEAT_DELAY;
    localparam int c_MAX    = (c_MAX_AB > REPEAT_PERIOD) ? c_MAX_AB : REPEAT_PERIOD;
    localparam int CNT_W    = $clog2(c_MAX + 1);

    localparam logic [CNT_W-1:0] c_DB_LAST  = CNT_W'(DEBOUNCE_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PRESS_DB = 2'd1,
        S_HELD     = 2'd2,
        S_REL_DB   = 2'd3
    } state_t;

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch

            logic             r_sync1;
            logic             r_sync2;
            state_t           r_state;
            state_t           w_state_nxt;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_nxt;
            logic             r_phase;      // 0 = first-repeat delay, 1 = repeat period
            logic             w_phase_nxt;
            logic             r_level;
            logic             w_level_nxt;
            logic             r_press;
            logic             w_press_nxt;
            logic             r_rel;
            logic             w_rel_nxt;

            // ---------------------------------------------------------------
            // Two-flop synchroniser; the FSM only ever looks at r_sync2.
            // ---------------------------------------------------------------
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= btn[gi];
                    r_sync2 <= r_sync1;
                end
            end

            // ---------------------------------------------------------------
            // State and output registers.
            // ---------------------------------------------------------------
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_phase <= 1'b0;
                    r_level <= 1'b0;
                    r_press <= 1'b0;
                    r_rel   <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_phase <= w_phase_nxt;
                    r_level <= w_level_nxt;
                    r_press <= w_press_nxt;
                    r_rel   <= w_rel_nxt;
                end
            end

            // ---------------------------------------------------------------
            // Next-state and next-output logic. Every terminal compare either
            // clears the counter or leaves the counting state, so the counter
            // can never wrap.
            // ---------------------------------------------------------------
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_phase_nxt = r_phase;
                w_level_nxt = r_level;
                w_press_nxt = 1'b0;
                w_rel_nxt   = 1'b0;

                case (r_state)
                    S_IDLE: begin
                        w_level_nxt = 1'b0;
                        if (r_sync2) begin
                            w_state_nxt = S_PRESS_DB;
                            w_cnt_nxt   = c_CNT_ONE;
                        end else begin
                            w_cnt_nxt   = c_CNT_ZERO;
                        end
                    end

                    S_PRESS_DB: begin
                        if (!r_sync2) begin
                            // Bounce: drop back silently.
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = c_CNT_ZERO;
                        end else if (r_cnt == c_DB_LAST) begin
                            w_state_nxt = S_HELD;
                            w_press_nxt = 1'b1;
                            w_level_nxt = 1'b1;
                            w_cnt_nxt   = c_CNT_ZERO;
                            w_phase_nxt = 1'b0;
                        end else begin
                            w_cnt_nxt   = r_cnt + c_CNT_ONE;
                        end
                    end

                    S_HELD: begin
                        if (!r_sync2) begin
                            w_state_nxt = S_REL_DB;
                            w_cnt_nxt   = c_CNT_ONE;
                        end else if (!repeat_en[gi]) begin
                            // Disabled repeat parks the timer at the start of
                            // the delay phase so re-enabling starts afresh.
                            w_cnt_nxt   = c_CNT_ZERO;
                            w_phase_nxt = 1'b0;
                        end else if (r_cnt == (r_phase ? c_RP_LAST : c_RD_LAST)) begin
                            w_press_nxt = 1'b1;
                            w_cnt_nxt   = c_CNT_ZERO;
                            w_phase_nxt = 1'b1;
                        end else begin
                            w_cnt_nxt   = r_cnt + c_CNT_ONE;
                        end
                    end

                    S_REL_DB: begin
                        if (r_sync2) begin
                            // Release bounce: back to held, repeat timing
                            // restarts from the delay phase.
                            w_state_nxt = S_HELD;
                            w_cnt_nxt   = c_CNT_ZERO;
                            w_phase_nxt = 1'b0;
                        end else if (r_cnt == c_DB_LAST) begin
                            w_state_nxt = S_IDLE;
                            w_rel_nxt   = 1'b1;
                            w_level_nxt = 1'b0;
                            w_cnt_nxt   = c_CNT_ZERO;
                        end else begin
                            w_cnt_nxt   = r_cnt + c_CNT_ONE;
                        end
                    end

                    default: begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = c_CNT_ZERO;
                        w_phase_nxt = 1'b0;
                        w_level_nxt = 1'b0;
                    end
                endcase
            end

            assign level[gi]       = r_level;
            assign press[gi]       = r_press;
            assign btn_release[gi] = r_rel;

        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_button_array.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_button_array
// Purpose  : Self-checking bench for button_array (N_BTN=2, DEBOUNCE_PERIOD=4,
//            REPEAT_DELAY=10, REPEAT_PERIOD=3). Stimulus pushes expected pulse
//            events into a queue; a monitor pops and compares on every pulse.
// Revision : 1.0  initial release
// ============================================================================
module tb_button_array;

    localparam int N   = 2;
    localparam int LAT = 5;   // capture edge to registered output

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn = '0;
    logic [N-1:0] repeat_en = '0;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] btn_release;

    button_array #(
        .N_BTN           (N),
        .DEBOUNCE_PERIOD (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .repeat_en   (repeat_en),
        .level       (level),
        .press       (press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    // edge_n equals the number of rising edges seen; sampled on falling edges.
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int cyc;
        int ch;
        bit rel;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic expect_ev(input int c, input int ch, input bit rel);
        q.push_back('{c, ch, rel});
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int e);
        while (edge_n < e) @(negedge clk);
    endtask

    task automatic check_pulse(input int ch, input bit rel);
        ev_t e;
        checks++;
        if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: ch %0d rel %0d at edge %0d, none expected",
                     ch, rel, edge_n);
        end else begin
            e = q.pop_front();
            if (e.cyc != edge_n || e.ch != ch || e.rel != rel) begin
                errors++;
                $display("FAIL pulse: got ch %0d rel %0d edge %0d expected ch %0d rel %0d edge %0d",
                         ch, rel, edge_n, e.ch, e.rel, e.cyc);
            end
        end
    endtask

    // Monitor: compares every observed pulse against the scoreboard queue.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc < edge_n) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse: ch %0d rel %0d expected at edge %0d, not observed by %0d",
                     q[0].ch, q[0].rel, q[0].cyc, edge_n);
            void'(q.pop_front());
        end
        for (int i = 0; i < N; i++) begin
            if (press[i] && btn_release[i]) begin
                checks++;
                errors++;
                $display("FAIL both_pulses: ch %0d press and release high at edge %0d", i, edge_n);
            end
            if (press[i])       check_pulse(i, 1'b0);
            if (btn_release[i]) check_pulse(i, 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish within 200000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int p;

        // ---------------- reset state ----------------
        tick(3);
        chk("reset_level",   level,       2'b00);
        chk("reset_press",   press,       2'b00);
        chk("reset_release", btn_release, 2'b00);
        rst = 1'b0;
        tick(2);

        // ---------------- 1: clean press / release ----------------
        btn[0] = 1'b1; k = edge_n + 1;
        expect_ev(k + LAT, 0, 1'b0);
        wait_until(k + LAT - 1);
        chk("t1_level_before", level, 2'b00);
        wait_until(k + LAT);
        chk("t1_level_after", level, 2'b01);
        tick(3);
        btn[0] = 1'b0; k = edge_n + 1;
        expect_ev(k + LAT, 0, 1'b1);
        wait_until(k + LAT - 1);
        chk("t1_rel_level_before", level, 2'b01);
        wait_until(k + LAT);
        chk("t1_rel_level_after", level, 2'b00);
        tick(3);

        // ---------------- 2: press bounce ----------------
        btn[0] = 1'b1; tick(3);
        btn[0] = 1'b0; tick(2);
        btn[0] = 1'b1; k = edge_n + 1;
        expect_ev(k + LAT, 0, 1'b0);
        wait_until(k + LAT - 1);
        chk("t2_level_before", level, 2'b00);
        wait_until(k + LAT);
        chk("t2_level_after", level, 2'b01);
        tick(2);

        // ---------------- 3: release glitch, then real release ----------------
        btn[0] = 1'b0; tick(2);
        btn[0] = 1'b1; tick(8);
        chk("t3_level_glitch", level, 2'b01);
        btn[0] = 1'b0; k = edge_n + 1;
        expect_ev(k + LAT, 0, 1'b1);
        wait_until(k + LAT - 1);
        chk("t3_level_before", level, 2'b01);
        wait_until(k + LAT);
        chk("t3_level_after", level, 2'b00);
        tick(3);

        // ---------------- 4a: auto-repeat ----------------
        repeat_en = 2'b01;
        btn[0] = 1'b1; k = edge_n + 1; p = k + LAT;
        expect_ev(p,      0, 1'b0);
        expect_ev(p + 10, 0, 1'b0);
        expect_ev(p + 13, 0, 1'b0);
        expect_ev(p + 16, 0, 1'b0);
        expect_ev(p + 19, 0, 1'b0);
        wait_until(p + 19);
        repeat_en = 2'b00;
        btn[0] = 1'b0; k = edge_n + 1;
        expect_ev(k + LAT, 0, 1'b1);
        wait_until(k + LAT);
        chk("t4a_level", level, 2'b00);
        tick(3);

        // ---------------- 4b: no repeat when disabled ----------------
        btn[0] = 1'b1; k = edge_n + 1; p = k + LAT;
        expect_ev(p, 0, 1'b0);
        wait_until(p + 20);
        chk("t4b_level_held", level, 2'b01);
        btn[0] = 1'b0; k = edge_n + 1;
        expect_ev(k + LAT, 0, 1'b1);
        wait_until(k + LAT);
        chk("t4b_level", level, 2'b00);
        tick(3);

        // ---------------- 4c: repeat_en toggled after first repeat ----------------
        // Off at edge p+12 resets to delay phase; back on, counting restarts
        // from 0 so next pulses are p+22 and p+25.
        repeat_en = 2'b01;
        btn[0] = 1'b1; k = edge_n + 1; p = k + LAT;
        expect_ev(p,      0, 1'b0);
        expect_ev(p + 10, 0, 1'b0);
        expect_ev(p + 22, 0, 1'b0);
        expect_ev(p + 25, 0, 1'b0);
        wait_until(p + 11);
        repeat_en = 2'b00;
        tick(1);
        repeat_en = 2'b01;
        wait_until(p + 25);
        repeat_en = 2'b00;
        btn[0] = 1'b0; k = edge_n + 1;
        expect_ev(k + LAT, 0, 1'b1);
        wait_until(k + LAT);
        chk("t4c_level", level, 2'b00);
        tick(3);

        // ---------------- 5: simultaneous channels ----------------
        btn = 2'b11; k = edge_n + 1;
        expect_ev(k + LAT, 0, 1'b0);
        expect_ev(k + LAT, 1, 1'b0);
        wait_until(k + LAT);
        chk("t5_level_both", level, 2'b11);
        tick(2);
        btn[1] = 1'b0; k = edge_n + 1;
        expect_ev(k + LAT, 1, 1'b1);
        wait_until(k + LAT);
        chk("t5_level_ch1_rel", level, 2'b01);
        tick(2);
        btn[0] = 1'b0; k = edge_n + 1;
        expect_ev(k + LAT, 0, 1'b1);
        wait_until(k + LAT);
        chk("t5_level_none", level, 2'b00);
        tick(3);

        // ---------------- 6: reset mid-operation ----------------
        btn[0] = 1'b1; tick(3);          // now in press debounce
        rst = 1'b1; #1;
        chk("t6_rst_pdb_level",   level,       2'b00);
        chk("t6_rst_pdb_press",   press,       2'b00);
        chk("t6_rst_pdb_release", btn_release, 2'b00);
        tick(2);
        rst = 1'b0; k = edge_n + 1;
        expect_ev(k + LAT, 0, 1'b0);
        wait_until(k + LAT - 1);
        chk("t6_level_before", level, 2'b00);
        wait_until(k + LAT);
        chk("t6_level_after", level, 2'b01);
        tick(3);                          // held
        rst = 1'b1; #1;
        chk("t6_rst_held_level",   level,       2'b00);
        chk("t6_rst_held_release", btn_release, 2'b00);
        tick(2);
        rst = 1'b0; k = edge_n + 1;
        expect_ev(k + LAT, 0, 1'b0);
        wait_until(k + LAT);
        chk("t6_level_repress", level, 2'b01);
        tick(2);
        btn[0] = 1'b0; k = edge_n + 1;
        expect_ev(k + LAT, 0, 1'b1);
        wait_until(k + LAT);
        chk("t6_level_final", level, 2'b00);
        tick(10);

        while (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL pending_pulse: ch %0d rel %0d expected at edge %0d, not observed",
                     q[0].ch, q[0].rel, q[0].cyc);
            void'(q.pop_front());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
